// File: rtl/msk_pkg.sv
// Shared helpers for the masked (share-wise) datapath blocks.
// Share layout: bit b of share s sits at index b*d+s.
package msk_pkg;

    // Flat index of lane b, share s in a d-share bus.
    function automatic int msk_idx(input int b, input int s, input int d);
        return b * d + s;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/msk_xor_accumulator_if.sv
// Operand / result streams of the masked XOR accumulator.
// The master side produces operands and randomness and consumes results.
interface msk_xor_accumulator_if #(
    parameter int d     = 2,
    parameter int count = 1
);
    logic [count*d-1:0]     in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [count*(d-1)-1:0] rnd;
    logic [count*d-1:0]     out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        output in_data, in_valid, rnd, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, rnd, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/MSKxor.sv
// Share-wise XOR of two sharings. Linear in every share, so no
// randomness is needed and shares are never combined.
module MSKxor #(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic [count*d-1:0] ina,
    input  logic [count*d-1:0] inb,
    output logic [count*d-1:0] out
);
    assign out = ina ^ inb;
endmodule

// File: rtl/msk_refresh.sv
// Additive refresh: shares 0..d-2 take one fresh bit each, the last
// share takes the parity of those bits, so the unshared value is kept.
module msk_refresh
    import msk_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic [count*d-1:0]     in_sh,
    input  logic [count*(d-1)-1:0] rnd,
    output logic [count*d-1:0]     out_sh
);

    for (genvar b = 0; b < count; b++) begin : g_lane
        logic [d-1:0] sh;

        // Per-lane refresh of the d shares of bit b.
        always_comb begin
            logic par;
            par = 1'b0;
            sh  = in_sh[msk_idx(b, 0, d) +: d];
            for (int s = 0; s < d - 1; s++) begin
                sh[s] = sh[s] ^ rnd[b*(d-1)+s];
                par   = par ^ rnd[b*(d-1)+s];
            end
            sh[d-1] = sh[d-1] ^ par;
        end

        assign out_sh[msk_idx(b, 0, d) +: d] = sh;
    end

endmodule

// File: rtl/msk_xor_accumulator.sv
// Masked multi-operand XOR accumulator: folds NOPS sharings into one,
// share-wise, and hands the (optionally refreshed) result out through
// a one-entry output register. in_ready depends combinationally on
// out_ready only for the completing operand of a frame.
module msk_xor_accumulator
    import msk_pkg::*;
#(
    parameter int d       = 2,
    parameter int count   = 1,
    parameter int NOPS    = 4,
    parameter int REFRESH = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    msk_xor_accumulator_if.slave bus
);

    localparam int            W     = count * d;
    localparam int            KW    = cnt_w(NOPS);
    localparam logic [KW-1:0] KLAST = KW'(NOPS - 1);

    logic [KW-1:0] k;
    logic [W-1:0]  acc;
    logic [W-1:0]  xor_res;
    logic [W-1:0]  res;
    logic [W-1:0]  ref_res;
    logic [W-1:0]  out_q;
    logic          out_vld;
    logic          busy_q;
    logic          last;
    logic          in_rdy;
    logic          fire;

    assign last   = (k == KLAST);
    // Only a completing operand can stall, and only while the previous
    // result is still waiting to be taken.
    assign in_rdy = !(last && out_vld && !bus.out_ready);
    assign fire   = bus.in_valid && in_rdy;

    // Share-wise fold of the incoming operand into the running value.
    for (genvar b = 0; b < count; b++) begin : g_xor
        MSKxor #(
            .d     (d),
            .count (1)
        ) u_xor (
            .ina (acc[msk_idx(b, 0, d) +: d]),
            .inb (bus.in_data[msk_idx(b, 0, d) +: d]),
            .out (xor_res[msk_idx(b, 0, d) +: d])
        );
    end

    // First operand of a frame replaces acc, so a stale frame needs no clear.
    assign res = (k == '0) ? bus.in_data : xor_res;

    if (REFRESH != 0) begin : g_refresh
        msk_refresh #(
            .d     (d),
            .count (count)
        ) u_refresh (
            .in_sh  (res),
            .rnd    (bus.rnd),
            .out_sh (ref_res)
        );
    end else begin : g_norefresh
        logic unused_rnd;
        assign unused_rnd = ^bus.rnd;
        assign ref_res    = res;
    end

    // Operand counter, accumulator and output register. A consume is
    // applied first so a same-cycle new result keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            acc     <= '0;
            out_q   <= '0;
            out_vld <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (out_vld && bus.out_ready)
                out_vld <= 1'b0;
            if (fire) begin
                acc <= res;
                if (last) begin
                    k       <= '0;
                    busy_q  <= 1'b0;
                    out_q   <= ref_res;
                    out_vld <= 1'b1;
                end else begin
                    k      <= k + 1'b1;
                    busy_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_vld;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_msk_xor_accumulator.sv
// Directed and randomized checks of the masked XOR accumulator.
// u0/u1: d=2 count=4 NOPS=3, identical stimulus, without/with refresh.
// u2: d=3 count=8 NOPS=1 with refresh.
module tb_msk_xor_accumulator;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    msk_xor_accumulator_if #(.d(2), .count(4)) if0 ();
    msk_xor_accumulator_if #(.d(2), .count(4)) if1 ();
    msk_xor_accumulator_if #(.d(3), .count(8)) if2 ();

    assign if1.in_data   = if0.in_data;
    assign if1.in_valid  = if0.in_valid;
    assign if1.rnd       = if0.rnd;
    assign if1.out_ready = if0.out_ready;

    msk_xor_accumulator #(.d(2), .count(4), .NOPS(3), .REFRESH(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    msk_xor_accumulator #(.d(2), .count(4), .NOPS(3), .REFRESH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    msk_xor_accumulator #(.d(3), .count(8), .NOPS(1), .REFRESH(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // share0 = v^m, share1 = m
    function automatic logic [7:0] share2(input logic [3:0] v, input logic [3:0] m);
        logic [7:0] r;
        for (int b = 0; b < 4; b++) begin
            r[2*b]   = v[b] ^ m[b];
            r[2*b+1] = m[b];
        end
        return r;
    endfunction

    function automatic logic [3:0] um2(input logic [7:0] x);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = x[2*b] ^ x[2*b+1];
        return r;
    endfunction

    function automatic logic [23:0] share3(input logic [7:0] v, input logic [7:0] m1, input logic [7:0] m2);
        logic [23:0] r;
        for (int b = 0; b < 8; b++) begin
            r[3*b]   = v[b] ^ m1[b] ^ m2[b];
            r[3*b+1] = m1[b];
            r[3*b+2] = m2[b];
        end
        return r;
    endfunction

    function automatic logic [7:0] um3(input logic [23:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[3*b] ^ x[3*b+1] ^ x[3*b+2];
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.rnd = '0; if0.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.rnd = '0; if2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ovalid0: got %b want 0", if0.out_valid); end
        n_cmp++; if (if0.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_odata0: got %h want 00", if0.out_data); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy0: got %b want 0", if0.busy); end
        n_cmp++; if (if1.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_odata1: got %h want 00", if1.out_data); end
        n_cmp++; if (if2.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ovalid2: got %b want 0", if2.out_valid); end
        n_cmp++; if (if2.out_data !== 24'h0) begin n_bad++; $display("FAIL rst_odata2: got %h want 000000", if2.out_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_inready0: got %b want 1", if0.in_ready); end
        n_cmp++; if (if2.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_inready2: got %b want 1", if2.in_ready); end
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ovalid0b: got %b want 0", if0.out_valid); end
    endtask

    // 0x3 ^ 0x5 ^ 0x9 = 0xF; masks 6^C^1 = B; refresh with A gives mask 1.
    task automatic test_frame();
        if0.out_ready = 1'b1; if0.rnd = 4'hA;
        if0.in_valid = 1'b1; if0.in_data = share2(4'h3, 4'h6);
        @(posedge clk); #1;
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL frame_busy_k1: got %b want 1", if0.busy); end
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_ovalid_k1: got %b want 0", if0.out_valid); end
        if0.in_data = share2(4'h5, 4'hC);
        @(posedge clk); #1;
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL frame_busy_k2: got %b want 1", if0.busy); end
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_ovalid_k2: got %b want 0", if0.out_valid); end
        if0.in_data = share2(4'h9, 4'h1);
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_bad++; $display("FAIL frame_ovalid: got %b want 1", if0.out_valid); end
        n_cmp++; if (if0.out_data !== share2(4'hF, 4'hB)) begin n_bad++; $display("FAIL frame_data_noref: got %h want %h", if0.out_data, share2(4'hF, 4'hB)); end
        n_cmp++; if (if1.out_data !== share2(4'hF, 4'h1)) begin n_bad++; $display("FAIL frame_data_ref: got %h want %h", if1.out_data, share2(4'hF, 4'h1)); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL frame_busy_done: got %b want 0", if0.busy); end
        @(posedge clk); #1;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_ovalid_1cyc: got %b want 0", if0.out_valid); end
        n_cmp++; if (if1.out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_ovalid_1cyc_ref: got %b want 0", if1.out_valid); end
    endtask

    // Frame 2: 1^2^4 = 7, masks 3^5^7 = 1; refresh with 5 gives mask 4.
    task automatic test_backpressure();
        if0.out_ready = 1'b0; if0.rnd = 4'hA; if0.in_valid = 1'b1;
        if0.in_data = share2(4'h3, 4'h6); @(posedge clk); #1;
        if0.in_data = share2(4'h5, 4'hC); @(posedge clk); #1;
        if0.in_data = share2(4'h9, 4'h1); @(posedge clk); #1;
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_f1_valid: got %b want 1", if0.out_valid); end
        n_cmp++; if (if1.out_data !== share2(4'hF, 4'h1)) begin n_bad++; $display("FAIL bp_f1_data_ref: got %h want %h", if1.out_data, share2(4'hF, 4'h1)); end
        if0.in_data = share2(4'h1, 4'h3); #1;
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_k0: got %b want 1", if0.in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (if0.out_data !== share2(4'hF, 4'hB)) begin n_bad++; $display("FAIL bp_hold1: got %h want %h", if0.out_data, share2(4'hF, 4'hB)); end
        if0.in_data = share2(4'h2, 4'h5); #1;
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_k1: got %b want 1", if0.in_ready); end
        @(posedge clk); #1;
        if0.in_data = share2(4'h4, 4'h7); if0.rnd = 4'h5; #1;
        n_cmp++; if (if0.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall0: got %b want 0", if0.in_ready); end
        n_cmp++; if (if1.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall1: got %b want 0", if1.in_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (if0.out_data !== share2(4'hF, 4'hB)) begin n_bad++; $display("FAIL bp_hold2: got %h want %h", if0.out_data, share2(4'hF, 4'hB)); end
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 1", if0.out_valid); end
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", if0.busy); end
        if0.out_ready = 1'b1; #1;
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", if0.in_ready); end
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_nogap: got %b want 1", if0.out_valid); end
        n_cmp++; if (if0.out_data !== share2(4'h7, 4'h1)) begin n_bad++; $display("FAIL bp_f2_data: got %h want %h", if0.out_data, share2(4'h7, 4'h1)); end
        n_cmp++; if (if1.out_data !== share2(4'h7, 4'h4)) begin n_bad++; $display("FAIL bp_f2_data_ref: got %h want %h", if1.out_data, share2(4'h7, 4'h4)); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy_done: got %b want 0", if0.busy); end
        @(posedge clk); #1;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", if0.out_valid); end
    endtask

    // Fresh frame after reset: 8^4^2 = E, masks 3^3^0 = 0; refresh F -> mask F.
    task automatic test_reset_midframe();
        if0.out_ready = 1'b1; if0.rnd = 4'hF; if0.in_valid = 1'b1;
        if0.in_data = share2(4'h8, 4'h3); @(posedge clk); #1;
        if0.in_data = share2(4'h4, 4'h3); @(posedge clk); #1;
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL mr_busy_pre: got %b want 1", if0.busy); end
        if0.in_valid = 1'b0;
        rst_n = 1'b0; #1;
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL mr_busy: got %b want 0", if0.busy); end
        n_cmp++; if (if0.out_data !== 8'h00) begin n_bad++; $display("FAIL mr_odata0: got %h want 00", if0.out_data); end
        n_cmp++; if (if1.out_data !== 8'h00) begin n_bad++; $display("FAIL mr_odata1: got %h want 00", if1.out_data); end
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_ovalid: got %b want 0", if0.out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1; if0.in_valid = 1'b1;
        if0.in_data = share2(4'h8, 4'h3); @(posedge clk); #1;
        if0.in_data = share2(4'h4, 4'h3); @(posedge clk); #1;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_early: got %b want 0", if0.out_valid); end
        if0.in_data = share2(4'h2, 4'h0); @(posedge clk); #1;
        if0.in_valid = 1'b0;
        n_cmp++; if (if0.out_valid !== 1'b1) begin n_bad++; $display("FAIL mr_valid: got %b want 1", if0.out_valid); end
        n_cmp++; if (if0.out_data !== share2(4'hE, 4'h0)) begin n_bad++; $display("FAIL mr_data: got %h want %h", if0.out_data, share2(4'hE, 4'h0)); end
        n_cmp++; if (if1.out_data !== share2(4'hE, 4'hF)) begin n_bad++; $display("FAIL mr_data_ref: got %h want %h", if1.out_data, share2(4'hE, 4'hF)); end
        @(posedge clk); #1;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_drain: got %b want 0", if0.out_valid); end
    endtask

    task automatic test_nops1();
        logic [23:0] e;
        if2.out_ready = 1'b1; if2.rnd = '0; if2.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = share3(8'(i), 8'(i * 37 + 5), 8'(i * 91 + 3));
            if2.in_data = e;
            @(posedge clk); #1;
            n_cmp++; if (if2.out_valid !== 1'b1) begin n_bad++; $display("FAIL n1_valid[%0d]: got %b want 1", i, if2.out_valid); end
            n_cmp++; if (if2.out_data !== e) begin n_bad++; $display("FAIL n1_data[%0d]: got %h want %h", i, if2.out_data, e); end
            n_cmp++; if (um3(if2.out_data) !== 8'(i)) begin n_bad++; $display("FAIL n1_unshared[%0d]: got %h want %h", i, um3(if2.out_data), 8'(i)); end
        end
        if2.in_data = '0;
        if2.rnd = 16'h0001; @(posedge clk); #1;
        n_cmp++; if (if2.out_data !== 24'h000005) begin n_bad++; $display("FAIL n1_ref_s0: got %h want 000005", if2.out_data); end
        if2.rnd = 16'h0002; @(posedge clk); #1;
        n_cmp++; if (if2.out_data !== 24'h000006) begin n_bad++; $display("FAIL n1_ref_s1: got %h want 000006", if2.out_data); end
        if2.rnd = 16'h8000; @(posedge clk); #1;
        n_cmp++; if (if2.out_data !== 24'hC00000) begin n_bad++; $display("FAIL n1_ref_lane7: got %h want c00000", if2.out_data); end
        if2.in_valid = 1'b0; @(posedge clk); #1;
        n_cmp++; if (if2.out_valid !== 1'b0) begin n_bad++; $display("FAIL n1_drain: got %b want 0", if2.out_valid); end
    endtask

    // Random valid/ready on u0/u1 against a model of k, out_valid and results.
    task automatic test_random_nops3();
        logic [3:0] q[$];
        logic [3:0] v, av, e;
        logic       ov, vld, rdy, exp_rdy;
        int         kk, nin, nout, cyc;
        ov = 1'b0; kk = 0; nin = 0; nout = 0; cyc = 0; av = '0;
        while (nout < 1000 && cyc < 30000) begin
            n_cmp++; if (if0.out_valid !== ov || if1.out_valid !== ov) begin n_bad++; $display("FAIL rnd3_ovalid cyc %0d: got %b/%b want %b", cyc, if0.out_valid, if1.out_valid, ov); end
            v   = 4'($urandom);
            vld = (nin < 3000) && ($urandom_range(3) != 0);
            rdy = ($urandom_range(1) == 1);
            if0.in_valid = vld; if0.in_data = share2(v, 4'($urandom));
            if0.rnd = 4'($urandom); if0.out_ready = rdy;
            #1;
            exp_rdy = !(kk == 2 && ov && !rdy);
            n_cmp++; if (if0.in_ready !== exp_rdy || if1.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd3_inready cyc %0d: got %b/%b want %b", cyc, if0.in_ready, if1.in_ready, exp_rdy); end
            if (ov && rdy) begin
                n_cmp++;
                if (q.size() == 0) begin n_bad++; $display("FAIL rnd3_dup cyc %0d: got result want none", cyc); end
                else begin
                    e = q.pop_front();
                    if (um2(if0.out_data) !== e || um2(if1.out_data) !== e) begin n_bad++; $display("FAIL rnd3_result %0d: got %h/%h want %h", nout, um2(if0.out_data), um2(if1.out_data), e); end
                end
                nout++; ov = 1'b0;
            end
            if (vld && exp_rdy) begin
                nin++;
                av = (kk == 0) ? v : (av ^ v);
                if (kk == 2) begin q.push_back(av); kk = 0; ov = 1'b1; end
                else kk++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if0.in_valid = 1'b0;
        n_cmp++; if (nout != 1000) begin n_bad++; $display("FAIL rnd3_timeout: got %0d results want 1000", nout); end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd3_lost: got %0d pending want 0", q.size()); end
        @(posedge clk); #1;
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd3_extra: got %b want 0", if0.out_valid); end
    endtask

    // Random valid/ready on u2 (one operand per frame).
    task automatic test_random_nops1();
        logic [7:0] q[$];
        logic [7:0] v, e;
        logic       ov, vld, rdy, exp_rdy;
        int         nin, nout, cyc;
        ov = 1'b0; nin = 0; nout = 0; cyc = 0;
        while (nout < 1000 && cyc < 30000) begin
            n_cmp++; if (if2.out_valid !== ov) begin n_bad++; $display("FAIL rnd1_ovalid cyc %0d: got %b want %b", cyc, if2.out_valid, ov); end
            v   = 8'($urandom);
            vld = (nin < 1000) && ($urandom_range(3) != 0);
            rdy = ($urandom_range(2) != 0);
            if2.in_valid = vld; if2.in_data = share3(v, 8'($urandom), 8'($urandom));
            if2.rnd = 16'($urandom); if2.out_ready = rdy;
            #1;
            exp_rdy = !(ov && !rdy);
            n_cmp++; if (if2.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd1_inready cyc %0d: got %b want %b", cyc, if2.in_ready, exp_rdy); end
            if (ov && rdy) begin
                n_cmp++;
                if (q.size() == 0) begin n_bad++; $display("FAIL rnd1_dup cyc %0d: got result want none", cyc); end
                else begin
                    e = q.pop_front();
                    if (um3(if2.out_data) !== e) begin n_bad++; $display("FAIL rnd1_result %0d: got %h want %h", nout, um3(if2.out_data), e); end
                end
                nout++; ov = 1'b0;
            end
            if (vld && exp_rdy) begin nin++; q.push_back(v); ov = 1'b1; end
            @(posedge clk); #1;
            cyc++;
        end
        if2.in_valid = 1'b0;
        n_cmp++; if (nout != 1000) begin n_bad++; $display("FAIL rnd1_timeout: got %0d results want 1000", nout); end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd1_lost: got %0d pending want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_reset_midframe();
        test_nops1();
        test_random_nops3();
        test_random_nops1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
